// File: rtl/register_file_2r1w_if.sv
// Register file access bundle: one write port and two read ports.
//
// Signals
//   wr_ena    write enable
//   wr_addr   write address   (ADDR_W bits)
//   wr_data   write data      (N bits)
//   rd_addr0  read port 0 address, rd_data0 read port 0 data
//   rd_addr1  read port 1 address, rd_data1 read port 1 data
//
// Modports
//   master  the side that issues addresses and write data (decode/writeback)
//   slave   the register file itself
interface register_file_2r1w_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
);
    logic              wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [N-1:0]      wr_data;
    logic [ADDR_W-1:0] rd_addr0;
    logic [N-1:0]      rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [N-1:0]      rd_data1;

    modport master (
        output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/register_file_2r1w.sv
// Parametrised register file with one synchronous write port and two
// independent combinational read ports, for the CPU operand path.
//
// Ports
//   clk   clock, all storage updates on the rising edge
//   rst   synchronous active-high reset, clears every register
//   bus   register_file_2r1w_if.slave: wr_ena/wr_addr/wr_data write port,
//         rd_addr0/rd_data0 and rd_addr1/rd_data1 read ports
//
// Parameters
//   N         data width
//   ADDR_W    address width
//   DEPTH     implemented registers (2..2**ADDR_W); other addresses read 0
//             and ignore writes
//   ZERO_REG  1: register 0 reads 0 and ignores writes
//   BYPASS    1: a same-cycle write is forwarded to a matching read port
module register_file_2r1w #(
    parameter int N        = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    register_file_2r1w_if.slave  bus
);

    logic [N-1:0] mem [DEPTH];
    logic         wr_legal;
    logic         fwd_ok;

    // An address names real, readable/writable storage only when it is below
    // DEPTH and is not the hardwired zero register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        logic in_range;
        in_range = ({{(32-ADDR_W){1'b0}}, a} < DEPTH);
        return in_range && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_legal = bus.wr_ena && addr_live(bus.wr_addr);

    // Forwarding follows exactly the writes that will land in storage, and
    // never while reset is discarding that write.
    assign fwd_ok = (BYPASS != 0) && wr_legal && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_legal) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data0 = '0;
        if (addr_live(bus.rd_addr0)) begin
            bus.rd_data0 = mem[bus.rd_addr0];
        end
        if (fwd_ok && (bus.rd_addr0 == bus.wr_addr)) begin
            bus.rd_data0 = bus.wr_data;
        end
    end

    always_comb begin
        bus.rd_data1 = '0;
        if (addr_live(bus.rd_addr1)) begin
            bus.rd_data1 = mem[bus.rd_addr1];
        end
        if (fwd_ok && (bus.rd_addr1 == bus.wr_addr)) begin
            bus.rd_data1 = bus.wr_data;
        end
    end

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w. Two instances share one stimulus stream:
//   dut_a: DEPTH=32, ZERO_REG=1, BYPASS=0
//   dut_b: DEPTH=20, ZERO_REG=0, BYPASS=1
// A behavioural model (plain arrays) predicts every read on every cycle;
// directed scenarios add literal expectations.
module tb_register_file_2r1w;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    logic [31:0] ma [32];
    logic [31:0] mb [32];

    always #5 clk = ~clk;

    register_file_2r1w_if #(.N(32), .ADDR_W(5)) ifa ();
    register_file_2r1w_if #(.N(32), .ADDR_W(5)) ifb ();

    assign ifa.wr_ena = wr_ena;   assign ifb.wr_ena = wr_ena;
    assign ifa.wr_addr = wr_addr; assign ifb.wr_addr = wr_addr;
    assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
    assign ifa.rd_addr0 = rd_addr0; assign ifb.rd_addr0 = rd_addr0;
    assign ifa.rd_addr1 = rd_addr1; assign ifb.rd_addr1 = rd_addr1;

    register_file_2r1w #(.N(32), .ADDR_W(5), .DEPTH(32), .ZERO_REG(1), .BYPASS(0))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    register_file_2r1w #(.N(32), .ADDR_W(5), .DEPTH(20), .ZERO_REG(0), .BYPASS(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    // Which writes each configuration accepts.
    function automatic bit legal(input int cfg, input logic [4:0] a);
        if (cfg == 0) return (a != 5'd0);
        return (a < 5'd20);
    endfunction

    // Expected read value for configuration cfg at address a, given the
    // current model contents and the inputs currently applied.
    function automatic logic [31:0] expect_rd(input int cfg, input logic [4:0] a);
        if (cfg == 1 && wr_ena && !rst && a == wr_addr && legal(1, wr_addr))
            return wr_data;
        if (!legal(cfg, a)) return 32'h0;
        return (cfg == 0) ? ma[a] : mb[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state update at the clock edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ma[i] <= 32'h0;
                mb[i] <= 32'h0;
            end
            armed <= 1'b1;
        end else if (wr_ena) begin
            if (legal(0, wr_addr)) ma[wr_addr] <= wr_data;
            if (legal(1, wr_addr)) mb[wr_addr] <= wr_data;
        end
    end

    // Every-cycle comparison of all four read ports against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("model_a_rd0", ifa.rd_data0, expect_rd(0, rd_addr0));
            check("model_a_rd1", ifa.rd_data1, expect_rd(0, rd_addr1));
            check("model_b_rd0", ifb.rd_data0, expect_rd(1, rd_addr0));
            check("model_b_rd1", ifb.rd_data1, expect_rd(1, rd_addr1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Settle to just after the model compare of the current cycle.
    task automatic probe();
        @(negedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_ena = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_ena = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        step(); step();
        rst = 1'b0;

        // Reset clear: a write coincident with rst is lost.
        wr(5'd5, 32'hDEADBEEF);
        rd_addr0 = 5'd5;
        probe();
        check("pre_reset_r5", ifa.rd_data0, 32'hDEADBEEF);
        rst = 1'b1; wr_ena = 1'b1; wr_addr = 5'd6; wr_data = 32'h12345678;
        step();
        rst = 1'b0; wr_ena = 1'b0;
        rd_addr0 = 5'd5; rd_addr1 = 5'd6;
        probe();
        check("reset_a_r5", ifa.rd_data0, 32'h0);
        check("reset_a_r6", ifa.rd_data1, 32'h0);
        check("reset_b_r5", ifb.rd_data0, 32'h0);
        check("reset_b_r6", ifb.rd_data1, 32'h0);

        // Write every register, then sweep with mirrored addresses.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A50000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i);
            probe();
            check("sweep_a_rd0", ifa.rd_data0, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
            check("sweep_a_rd1", ifa.rd_data1, (i == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - i));
        end

        // Zero register: hardwired in dut_a, ordinary storage in dut_b.
        wr(5'd0, 32'hFFFFFFFF);
        rd_addr0 = 5'd0; rd_addr1 = 5'd0;
        probe();
        check("zero_a_rd0", ifa.rd_data0, 32'h0);
        check("zero_a_rd1", ifa.rd_data1, 32'h0);
        check("zero_b_rd0", ifb.rd_data0, 32'hFFFFFFFF);
        check("zero_b_rd1", ifb.rd_data1, 32'hFFFFFFFF);

        // Bypass timing.
        wr(5'd7, 32'h11111111);
        wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222; rd_addr0 = 5'd7;
        probe();
        check("nobypass_before", ifa.rd_data0, 32'h11111111);
        check("bypass_before", ifb.rd_data0, 32'h22222222);
        step();
        wr_ena = 1'b0;
        probe();
        check("nobypass_after", ifa.rd_data0, 32'h22222222);
        check("bypass_after", ifb.rd_data0, 32'h22222222);

        // Out of range for dut_b (DEPTH=20); the model sweep confirms no change.
        wr(5'd25, 32'h00001234);
        rd_addr0 = 5'd25;
        probe();
        check("oor_b_rd0", ifb.rd_data0, 32'h0);
        check("oor_a_rd0", ifa.rd_data0, 32'h00001234);
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            probe();
        end
        rd_addr1 = 5'd19;
        probe();
        check("oor_b_r19", ifb.rd_data1, 32'hA5A50013);

        // Enable low holds the register.
        wr(5'd3, 32'h0000AAAA);
        wr_addr = 5'd3; wr_data = 32'h00005555; rd_addr0 = 5'd3;
        for (int i = 0; i < 10; i++) step();
        probe();
        check("hold_a_r3", ifa.rd_data0, 32'h0000AAAA);
        check("hold_b_r3", ifb.rd_data0, 32'h0000AAAA);

        // Randomized traffic, including occasional mid-operation resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wr_ena   = $urandom_range(0, 1);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0; wr_ena = 1'b0;
        probe();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
